// File: rtl/n_bit_divider_seq_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// The master drives the request; the slave returns the result.
interface n_bit_divider_seq_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/n_bit_divider_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// A ripple adder with cin=1 performs each trial subtraction.
module n_bit_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) |
                      (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];
endmodule

module n_bit_divider_seq #(
  parameter int N = 8
) (
  input logic clk,
  input logic rst,
  n_bit_divider_seq_if.slave bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  d_r, d_d;
  logic [N-1:0]  quo_w, quo_d;
  logic [N:0]    rem_w, rem_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [N-1:0]  q_r, q_d;
  logic [N-1:0]  r_r, r_d;
  logic          z_r, z_d;

  logic [N:0]    s;
  logic [N:0]    t;
  logic          cout;

  assign s = {rem_w[N-1:0], quo_w[N-1]};

  n_bit_adder #(.W(N + 1)) u_sub (
    .a    (s),
    .b    (~{1'b0, d_r}),
    .cin  (1'b1),
    .sum  (t),
    .cout (cout)
  );

  // The remainder never exceeds N bits, so the top bit stays zero.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_w[N];

  always_comb begin
    state_d = state_q;
    d_d     = d_r;
    quo_d   = quo_w;
    rem_d   = rem_w;
    cnt_d   = cnt;
    q_d     = q_r;
    r_d     = r_r;
    z_d     = z_r;
    case (state_q)
      CALC: begin
        rem_d = cout ? t : s;
        quo_d = {quo_w[N-2:0], cout};
        cnt_d = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_d = DONE;
          q_d     = quo_d;
          r_d     = rem_d[N-1:0];
          z_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        if (bus.start) begin
          if (bus.divisor != '0) begin
            state_d = CALC;
            d_d     = bus.divisor;
            quo_d   = bus.dividend;
            rem_d   = '0;
            cnt_d   = CW'(N);
          end else begin
            state_d = DONE;
            q_d     = '1;
            r_d     = bus.dividend;
            z_d     = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d_r     <= '0;
      quo_w   <= '0;
      rem_w   <= '0;
      cnt     <= '0;
      q_r     <= '0;
      r_r     <= '0;
      z_r     <= 1'b0;
    end else begin
      state_q <= state_d;
      d_r     <= d_d;
      quo_w   <= quo_d;
      rem_w   <= rem_d;
      cnt     <= cnt_d;
      q_r     <= q_d;
      r_r     <= r_d;
      z_r     <= z_d;
    end
  end

  assign bus.busy        = (state_q == CALC);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = q_r;
  assign bus.remainder   = r_r;
  assign bus.div_by_zero = z_r;
endmodule

// File: tb/tb_n_bit_divider_seq.sv
// Directed and random checks for the sequential divider.
// Outputs are sampled on the falling edge.
module tb_n_bit_divider_seq;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  n_bit_divider_seq_if #(.N(N)) bus ();

  n_bit_divider_seq #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d",
               tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int k,
                           output int bc);
    k  = 1;
    bc = 0;
    while (!bus.done && k < 40) begin
      if (bus.busy) bc++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [N-1:0] a,
                     input logic [N-1:0] b,
                     input logic [N-1:0] eq,
                     input logic [N-1:0] er,
                     input logic ez);
    int k, bc;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k, bc);
    chk({tag, "_lat"}, k, ez ? 1 : N + 1);
    chk({tag, "_busy"}, bc, ez ? 0 : N);
    chk({tag, "_q"}, bus.quotient, eq);
    chk({tag, "_r"}, bus.remainder, er);
    chk({tag, "_z"}, bus.div_by_zero, ez);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.done, 0);
  endtask

  initial begin
    int k, bc;
    logic [N-1:0] a, b;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    chk("rst_z", bus.div_by_zero, 0);

    run("b100_7", 100, 7, 14, 2, 0);
    run("b255_1", 255, 1, 255, 0, 0);
    run("b5_9", 5, 9, 0, 5, 0);
    run("b255_255", 255, 255, 1, 0, 0);
    run("b0_13", 0, 13, 0, 0, 0);
    run("dz200", 200, 0, 8'hFF, 200, 1);
    run("b9_3", 9, 3, 3, 0, 0);

    // back-to-back with start held high
    bus.start    = 1'b1;
    bus.dividend = 100;
    bus.divisor  = 7;
    @(posedge clk);
    @(negedge clk);
    bus.dividend = 250;
    bus.divisor  = 16;
    wait_done(k, bc);
    chk("bb1_lat", k, N + 1);
    chk("bb1_q", bus.quotient, 14);
    chk("bb1_r", bus.remainder, 2);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("bb_noidle", bus.busy, 1);
    chk("bb_hold_q", bus.quotient, 14);
    wait_done(k, bc);
    chk("bb2_gap", k, N + 1);
    chk("bb2_q", bus.quotient, 15);
    chk("bb2_r", bus.remainder, 10);
    @(negedge clk);

    // start pulse during CALC is ignored
    bus.start    = 1'b1;
    bus.dividend = 100;
    bus.divisor  = 7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 50;
    bus.divisor  = 5;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k, bc);
    chk("ign_lat", k, N - 1);
    chk("ign_q", bus.quotient, 14);
    chk("ign_r", bus.remainder, 2);
    @(negedge clk);

    // reset in the 4th CALC cycle
    bus.start    = 1'b1;
    bus.dividend = 100;
    bus.divisor  = 7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.done, 0);
    chk("mr_q", bus.quotient, 0);
    chk("mr_r", bus.remainder, 0);
    chk("mr_z", bus.div_by_zero, 0);
    bc = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) bc++;
    end
    chk("mr_quiet", bc, 0);
    run("b81_9", 81, 9, 9, 0, 0);

    for (int i = 0; i < 1000; i++) begin
      a = N'($urandom);
      b = N'($urandom_range(1, (1 << N) - 1));
      run("rnd", a, b, a / b, a % b, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
